lfsr_delay_gen: RTL and testbench
=================================

# lfsr_delay_gen

Parametrised Fibonacci LFSR with seed load, lock-up protection and a random-delay countdown timer. It supplies pseudo-random bits and words to the game logic. It also generates the random "get ready → go" wait: on `start` it captures a delay from the LFSR, counts that many `tick` pulses, then pulses `done`. It replaces the fixed 10-bit single-bit generator and the ad-hoc wait counters around it.

## Interface
- `WIDTH`, 10: LFSR length in bits; legal range 4..32.
- `TAP_MASK`, 10'h009: feedback taps. Feedback bit = XOR of `lfsr[i]` for every set bit i. The default gives a maximal period of 1023.
- `SEED`, 1: reset value; also substituted for an all-zero load. Must be non-zero.
- `DELAY_BITS`, 6: number of LFSR LSBs used as the random delay part; must be ≤ `WIDTH`.
- `MIN_DELAY`, 4: fixed delay offset in ticks; 1..2^`DELAY_BITS`.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `step_en` in 1: advance the LFSR one step this cycle.
- `seed_load` in 1: load `seed_in` into the LFSR.
- `seed_in` in `WIDTH`: seed value.
- `start` in 1: request a random delay (one-cycle pulse or level).
- `abort` in 1: cancel a running delay.
- `tick` in 1: timebase pulse for the countdown.
- `rand_bit` out 1: `lfsr[WIDTH-1]`.
- `rand_word` out `WIDTH`: full LFSR state.
- `busy` out 1: high while a delay is in progress.
- `done` out 1: one-cycle pulse when a delay expires.
- `last_delay` out `DELAY_BITS+1`: delay captured at the most recent accepted `start`.

## Operation
- LFSR step: `lfsr[WIDTH-2:0] <= lfsr[WIDTH-1:1]`; `lfsr[WIDTH-1] <= ^(lfsr & TAP_MASK)`.
- LFSR update priority: `seed_load` > `step_en` > hold.
- Zero protection: `seed_load` with `seed_in == 0` loads `SEED`. The register can never hold all zeros.
- The LFSR runs independently of the timer. Stepping continues while `busy`.
- Delay count D = `MIN_DELAY` + `lfsr[DELAY_BITS-1:0]`. It is taken from the register value before any same-cycle load or step.
- Counter width is `DELAY_BITS+1`, and D never overflows it. Maximum D is `MIN_DELAY` + 2^`DELAY_BITS` − 1.
- FSM states:
  - IDLE: `busy=0`. Goes to COUNT when `start=1` and `abort=0`. On entry the counter is set to D and `last_delay` is set to D.
  - COUNT: `busy=1`. Each `tick` decrements the counter. A `tick` with counter == 1 goes to FIRE. `abort=1` goes to IDLE with no `done`.
  - FIRE: `done=1` and `busy=0` for exactly one cycle, then unconditionally back to IDLE. `start` in FIRE is ignored.
- `start` while in COUNT or FIRE is ignored; there is no re-trigger and no queueing.
- Reset values: `lfsr=SEED`, state IDLE, counter 0, `last_delay=0`, `busy=0`, `done=0`, `rand_bit=SEED[WIDTH-1]`, `rand_word=SEED`.
- Reset mid-COUNT returns immediately to IDLE. No `done` is produced.

## Timing
- `rand_bit` and `rand_word` are registered. They reflect a step or load one cycle after the enabling edge.
- `busy` rises the cycle after `start` is sampled in IDLE.
- `tick` in the same cycle as an accepted `start` is not counted. Counting begins the following cycle.
- `done` is asserted the cycle after the D-th counted `tick`. `busy` falls in that same cycle.
- `abort` and the final `tick` in the same cycle: abort wins. No `done`; IDLE next cycle.
- `abort` and `start` in IDLE in the same cycle: nothing happens.
- `seed_load` and `start` in the same cycle: D comes from the old LFSR value and the new seed is loaded.
- Back-to-back delays: the earliest a new `start` can be accepted is the cycle after FIRE. Minimum spacing is therefore D+2 cycles when `tick` is held high.

## Test plan
- Reset, then 2 cycles of `step_en` (defaults): `rand_word` goes 0x001 → 0x200 → 0x100; `rand_bit` goes 0 → 1 → 0.
- Period check: 1023 consecutive steps from 0x001 return to 0x001. No earlier repeat and never 0x000.
- `seed_load` with `seed_in=0x000`: `rand_word` becomes 0x001. `seed_load` plus `step_en` with 0x155: `rand_word` becomes 0x155 (load wins).
- After reset, `start` with `tick` high every cycle: `last_delay=5`, `busy` high for 5 cycles, one `done` pulse, then IDLE. A `start` held high during COUNT causes no second delay.
- `seed_in=0x03F` loaded, then `start` with `tick` every 3rd cycle: D=67. `done` arrives the cycle after the 67th counted tick.
- `abort` coincident with the final `tick`: no `done` and `busy` low next cycle. Async `rst` mid-COUNT: all outputs return to reset values immediately.

Source files
------------

// File: rtl/lfsr_delay_gen.sv
// Fibonacci LFSR random source with seed load and lock-up protection,
// plus a random "get ready -> go" countdown timer. On start the timer captures
// MIN_DELAY plus the LFSR's low bits, counts that many tick pulses, then pulses done.
module lfsr_delay_gen #(
    parameter int               WIDTH      = 10,
    parameter logic [WIDTH-1:0] TAP_MASK   = WIDTH'(10'h009),
    parameter logic [WIDTH-1:0] SEED       = WIDTH'(1),
    parameter int               DELAY_BITS = 6,
    parameter int               MIN_DELAY  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  step_en,
    input  logic                  seed_load,
    input  logic [WIDTH-1:0]      seed_in,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  tick,
    output logic                  rand_bit,
    output logic [WIDTH-1:0]      rand_word,
    output logic                  busy,
    output logic                  done,
    output logic [DELAY_BITS:0]   last_delay
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        FIRE  = 2'd2
    } state_t;

    // The counter is one bit wider than the random part, so the largest
    // delay (MIN_DELAY + 2^DELAY_BITS - 1) always fits.
    localparam logic [DELAY_BITS:0] MinDelayC = (DELAY_BITS+1)'(MIN_DELAY);
    localparam logic [DELAY_BITS:0] OneC      = (DELAY_BITS+1)'(1);

    logic [WIDTH-1:0]    lfsr_q, lfsr_d;
    state_t              state_q, state_d;
    logic [DELAY_BITS:0] cnt_q, cnt_d;
    logic [DELAY_BITS:0] last_delay_q, last_delay_d;
    logic [DELAY_BITS:0] delayValue;

    // Delay is drawn from the current register value, before any same-cycle load or step.
    assign delayValue = MinDelayC + {1'b0, lfsr_q[DELAY_BITS-1:0]};

    // LFSR next state: a load beats a step; an all-zero load is replaced by SEED
    // so the register can never lock up at zero.
    always_comb begin
        lfsr_d = lfsr_q;
        if (seed_load) begin
            lfsr_d = (seed_in == '0) ? SEED : seed_in;
        end else if (step_en) begin
            lfsr_d = {^(lfsr_q & TAP_MASK), lfsr_q[WIDTH-1:1]};
        end
    end

    // Timer next state: arm from IDLE, count ticks in COUNT, one-cycle FIRE pulse.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_delay_d = last_delay_q;
        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    state_d      = COUNT;
                    cnt_d        = delayValue;
                    last_delay_d = delayValue;
                end
            end
            COUNT: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (tick) begin
                    cnt_d = cnt_q - OneC;
                    if (cnt_q == OneC) begin
                        state_d = FIRE;
                    end
                end
            end
            FIRE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers with asynchronous reset back to the seed and an idle timer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q       <= SEED;
            state_q      <= IDLE;
            cnt_q        <= '0;
            last_delay_q <= '0;
        end else begin
            lfsr_q       <= lfsr_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_delay_q <= last_delay_d;
        end
    end

    assign rand_bit   = lfsr_q[WIDTH-1];
    assign rand_word  = lfsr_q;
    assign busy       = (state_q == COUNT);
    assign done       = (state_q == FIRE);
    assign last_delay = last_delay_q;

endmodule

// File: tb/tb_lfsr_delay_gen.sv
// Testbench for lfsr_delay_gen: directed scenarios plus randomized traffic, all
// compared against a cycle-level behavioural model of the LFSR and the delay timer.
module tb_lfsr_delay_gen;

    localparam int               W    = 10;
    localparam int               DB   = 6;
    localparam int               MIND = 4;
    localparam logic [W-1:0]     TAPS = 10'h009;
    localparam logic [W-1:0]     SEEDV = 10'h001;

    logic          clk;
    logic          rst;
    logic          step_en;
    logic          seed_load;
    logic [W-1:0]  seed_in;
    logic          start;
    logic          abort;
    logic          tick;
    logic          rand_bit;
    logic [W-1:0]  rand_word;
    logic          busy;
    logic          done;
    logic [DB:0]   last_delay;

    int vectors = 0;
    int miscompares = 0;

    // Behavioural model: the LFSR word, and the timer as "armed with N ticks to go"
    // plus a pending done pulse.
    logic [W-1:0] mWord;
    bit           mActive;
    bit           mFire;
    int           mLeft;
    int           mLast;

    lfsr_delay_gen #(
        .WIDTH(W), .TAP_MASK(TAPS), .SEED(SEEDV), .DELAY_BITS(DB), .MIN_DELAY(MIND)
    ) dut (
        .clk(clk), .rst(rst), .step_en(step_en), .seed_load(seed_load),
        .seed_in(seed_in), .start(start), .abort(abort), .tick(tick),
        .rand_bit(rand_bit), .rand_word(rand_word), .busy(busy), .done(done),
        .last_delay(last_delay)
    );

    // Free-running 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic logic [W-1:0] modelNext(input logic [W-1:0] w);
        int fb;
        int v;
        fb = $countones(w & TAPS) % 2;
        v  = (int'(w) >> 1) + fb * (1 << (W-1));
        return W'(v);
    endfunction

    task automatic modelReset();
        mWord   = SEEDV;
        mActive = 0;
        mFire   = 0;
        mLeft   = 0;
        mLast   = 0;
    endtask

    task automatic modelStep(input bit stepIn, input bit loadIn, input logic [W-1:0] seedVal,
                             input bit startIn, input bit abortIn, input bit tickIn);
        int d;
        d = MIND + (int'(mWord) % (1 << DB));
        if (mFire) begin
            mFire = 0;
        end else if (mActive) begin
            if (abortIn) begin
                mActive = 0;
            end else if (tickIn) begin
                mLeft--;
                if (mLeft == 0) begin
                    mActive = 0;
                    mFire   = 1;
                end
            end
        end else if (startIn && !abortIn) begin
            mActive = 1;
            mLeft   = d;
            mLast   = d;
        end
        if (loadIn) mWord = (seedVal == '0) ? SEEDV : seedVal;
        else if (stepIn) mWord = modelNext(mWord);
    endtask

    task automatic compareAll(input string pfx);
        checkOutput({pfx, "_word"}, 32'(rand_word), 32'(mWord));
        checkOutput({pfx, "_bit"}, 32'(rand_bit), 32'(mWord[W-1]));
        checkOutput({pfx, "_busy"}, 32'(busy), 32'(mActive));
        checkOutput({pfx, "_done"}, 32'(done), 32'(mFire));
        checkOutput({pfx, "_last"}, 32'(last_delay), 32'(mLast));
    endtask

    // One clock cycle: drive inputs (called at a falling edge), let the rising edge
    // happen, advance the model and compare, then return at the next falling edge.
    task automatic applyStimulus(input bit stepIn, input bit loadIn, input logic [W-1:0] seedVal,
                                 input bit startIn, input bit abortIn, input bit tickIn);
        step_en   = stepIn;
        seed_load = loadIn;
        seed_in   = seedVal;
        start     = startIn;
        abort     = abortIn;
        tick      = tickIn;
        @(posedge clk);
        #1;
        modelStep(stepIn, loadIn, seedVal, startIn, abortIn, tickIn);
        compareAll("cyc");
        @(negedge clk);
    endtask

    // Raise reset away from any clock edge and check it acts immediately.
    task automatic doReset();
        step_en = 0; seed_load = 0; seed_in = '0; start = 0; abort = 0; tick = 0;
        rst = 1'b1;
        #1;
        modelReset();
        compareAll("rst");
        @(posedge clk);
        #1;
        compareAll("rsthold");
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int firstReturn;
        int zeroSeen;
        int busyCycles;
        int donePulses;
        int ticksCounted;
        int lastTickCycle;
        int doneCycle;

        rst = 0; step_en = 0; seed_load = 0; seed_in = '0; start = 0; abort = 0; tick = 0;
        @(negedge clk);

        // Reset values and the first two steps from the default seed.
        doReset();
        checkOutput("reset_word", 32'(rand_word), 32'h001);
        applyStimulus(1, 0, '0, 0, 0, 0);
        checkOutput("step1_word", 32'(rand_word), 32'h200);
        checkOutput("step1_bit", 32'(rand_bit), 32'h1);
        applyStimulus(1, 0, '0, 0, 0, 0);
        checkOutput("step2_word", 32'(rand_word), 32'h100);
        checkOutput("step2_bit", 32'(rand_bit), 32'h0);

        // Full period from 0x001: first return after exactly 1023 steps, never zero.
        doReset();
        firstReturn = 0;
        zeroSeen = 0;
        for (int i = 1; i <= 1023; i++) begin
            applyStimulus(1, 0, '0, 0, 0, 0);
            if (rand_word == '0) zeroSeen++;
            if (rand_word == 10'h001 && firstReturn == 0) firstReturn = i;
        end
        checkOutput("period", 32'(firstReturn), 32'd1023);
        checkOutput("zero_state", 32'(zeroSeen), 32'd0);

        // Zero load is replaced by the seed; a load beats a step.
        applyStimulus(1, 0, '0, 0, 0, 0);
        applyStimulus(0, 1, 10'h000, 0, 0, 0);
        checkOutput("load_zero", 32'(rand_word), 32'h001);
        applyStimulus(1, 1, 10'h155, 0, 0, 0);
        checkOutput("load_wins", 32'(rand_word), 32'h155);

        // Delay from reset seed with tick every cycle; start held through COUNT.
        doReset();
        busyCycles = 0;
        donePulses = 0;
        for (int i = 0; i < 16; i++) begin
            applyStimulus(0, 0, '0, (i < 5), 0, 1);
            if (busy) busyCycles++;
            if (done) donePulses++;
        end
        checkOutput("d5_last", 32'(last_delay), 32'd5);
        checkOutput("d5_busy_cycles", 32'(busyCycles), 32'd5);
        checkOutput("d5_done_pulses", 32'(donePulses), 32'd1);
        checkOutput("d5_idle_after", 32'(busy), 32'd0);

        // Seed 0x03F gives D=67; tick every third cycle.
        doReset();
        applyStimulus(0, 1, 10'h03F, 0, 0, 0);
        ticksCounted = 0;
        lastTickCycle = -1;
        doneCycle = -1;
        for (int i = 0; i < 400; i++) begin
            applyStimulus(0, 0, '0, (i == 0), 0, (i % 3 == 0));
            if (i >= 1 && (i % 3 == 0)) begin
                ticksCounted++;
                lastTickCycle = i;
            end
            if (done) begin
                doneCycle = i;
                break;
            end
        end
        checkOutput("d67_timeout", 32'(doneCycle >= 0), 32'd1);
        checkOutput("d67_last", 32'(last_delay), 32'd67);
        checkOutput("d67_ticks", 32'(ticksCounted), 32'd67);
        checkOutput("d67_latency", 32'(doneCycle), 32'(lastTickCycle));

        // Abort coincident with the final tick: no done, idle next cycle.
        doReset();
        donePulses = 0;
        for (int i = 0; i <= 5; i++) begin
            applyStimulus(0, 0, '0, (i == 0), (i == 5), 1);
            if (done) donePulses++;
        end
        checkOutput("abort_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, '0, 0, 0, 1);
            if (done) donePulses++;
        end
        checkOutput("abort_nodone", 32'(donePulses), 32'd0);

        // Async reset in the middle of a countdown.
        applyStimulus(1, 0, '0, 1, 0, 1);
        applyStimulus(1, 0, '0, 0, 0, 1);
        applyStimulus(1, 0, '0, 0, 0, 0);
        checkOutput("midcount_busy", 32'(busy), 32'd1);
        doReset();
        checkOutput("midcount_rst_busy", 32'(busy), 32'd0);
        checkOutput("midcount_rst_last", 32'(last_delay), 32'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            bit sSt;
            bit sLd;
            bit sGo;
            bit sAb;
            bit sTk;
            logic [W-1:0] sSeed;
            sSt   = 1'($urandom_range(0, 1));
            sLd   = ($urandom_range(0, 19) == 0);
            sSeed = ($urandom_range(0, 3) == 0) ? '0 : W'($urandom);
            sGo   = ($urandom_range(0, 9) == 0);
            sAb   = ($urandom_range(0, 29) == 0);
            sTk   = 1'($urandom_range(0, 1));
            applyStimulus(sSt, sLd, sSeed, sGo, sAb, sTk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
